// File: rtl/data_mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_pkg
// Purpose  : Shared definitions for the data memory arbiter and the data
//            memory it drives. These are the arbiter FSM state encoding and
//            the default data and address widths.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

    localparam int c_DEF_WIDTH      = 12;
    localparam int c_DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotating-priority pick. The scan starts one
//            position after i_last_grant and wraps around.
// Ports    : i_req        - per-requester request vector
//            i_last_grant - index granted most recently
//            o_grant_idx  - winning requester (valid only with o_valid)
//            o_valid      - at least one request is present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0]         i_req,
    input  logic [$clog2(NUM_CORES)-1:0] i_last_grant,
    output logic [$clog2(NUM_CORES)-1:0] o_grant_idx,
    output logic                         o_valid
);

    localparam int c_IDX_W = $clog2(NUM_CORES);

    logic [c_IDX_W-1:0] w_idx;
    logic               w_valid;

    // (base + k) mod NUM_CORES for k in 1..NUM_CORES. NUM_CORES need not be
    // a power of two, so the wrap is done explicitly.
    function automatic logic [c_IDX_W-1:0] wrap_add(
        input logic [c_IDX_W-1:0] base,
        input int                 k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return c_IDX_W'(s);
    endfunction

    always_comb begin
        w_valid = 1'b0;
        w_idx   = '0;
        // k = NUM_CORES revisits the last grantee itself, so it has the lowest priority.
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!w_valid && i_req[wrap_add(i_last_grant, k)]) begin
                w_valid = 1'b1;
                w_idx   = wrap_add(i_last_grant, k);
            end
        end
    end

    assign o_grant_idx = w_idx;
    assign o_valid     = w_valid;

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Lets NUM_CORES cores share one single-port data memory. The
//            memory registers its address on the clock edge and returns read
//            data one cycle later. Requests are granted round-robin. Write
//            acks arrive 2 cycles after grant and read acks 3 cycles after.
// Ports    : clock, reset          - clock / async active-high reset
//            coreReq/We/Addr/WData - per-core request, packed buses
//            coreAck               - one-cycle completion pulse
//            coreRData             - shared read data, held until next read
//            memWriteEn/Address/DataIn, memDataOut - memory side
//            busy                  - transaction in progress
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            coreReq,
    input  logic [NUM_CORES-1:0]            coreWe,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] coreAddr,
    input  logic [NUM_CORES*WIDTH-1:0]      coreWData,
    output logic [NUM_CORES-1:0]            coreAck,
    output logic [WIDTH-1:0]                coreRData,
    output logic                            memWriteEn,
    output logic [ADDR_WIDTH-1:0]           memAddress,
    output logic [WIDTH-1:0]                memDataIn,
    input  logic [WIDTH-1:0]                memDataOut,
    output logic                            busy
);

    localparam int                   c_IDX_W = $clog2(NUM_CORES);
    localparam logic [NUM_CORES-1:0] c_ONE   = NUM_CORES'(1);

    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_grant;
    logic [c_IDX_W-1:0]     r_last;
    logic                   r_op_write;
    logic [NUM_CORES-1:0]   r_ack;
    logic [WIDTH-1:0]       r_rdata;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [WIDTH-1:0]       r_wdata;
    logic                   r_busy;

    logic [c_IDX_W-1:0]     w_pick_idx;
    logic                   w_pick_valid;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_arbiter (
        .i_req        (coreReq),
        .i_last_grant (r_last),
        .o_grant_idx  (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    // The ack is raised on the edge that enters RESP. This keeps the output
    // registered while it is high exactly during the RESP cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_last     <= c_IDX_W'(NUM_CORES - 1);
            r_op_write <= 1'b0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant    <= w_pick_idx;
                        r_addr     <= coreAddr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata    <= coreWData[w_pick_idx*WIDTH +: WIDTH];
                        r_we       <= coreWe[w_pick_idx];
                        r_op_write <= coreWe[w_pick_idx];
                        r_busy     <= 1'b1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory samples address/writeEn at this edge; drop the
                    // write strobe so it is exactly one cycle wide.
                    r_we <= 1'b0;
                    if (r_op_write) begin
                        r_ack   <= c_ONE << r_grant;
                        r_state <= RESP;
                    end else begin
                        r_state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    r_rdata <= memDataOut;
                    r_ack   <= c_ONE << r_grant;
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack   <= '0;
                    r_last  <= r_grant;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign coreAck    = r_ack;
    assign coreRData  = r_rdata;
    assign memWriteEn = r_we;
    assign memAddress = r_addr;
    assign memDataIn  = r_wdata;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Self-checking bench for data_mem_arbiter with a behavioural
//            single-port data memory. The stimulus process grants requests
//            with a transaction-level round-robin model and queues the
//            expected acks. A monitor pops the queue and compares each ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int AW = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      coreReq = '0;
    logic [N-1:0]      coreWe = '0;
    logic [N*AW-1:0]   coreAddr = '0;
    logic [N*W-1:0]    coreWData = '0;
    logic [N-1:0]      coreAck;
    logic [W-1:0]      coreRData;
    logic              memWriteEn;
    logic [AW-1:0]     memAddress;
    logic [W-1:0]      memDataIn;
    logic [W-1:0]      memDataOut;
    logic              busy;

    data_mem_arbiter #(
        .NUM_CORES  (N),
        .WIDTH      (W),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .coreReq    (coreReq),
        .coreWe     (coreWe),
        .coreAddr   (coreAddr),
        .coreWData  (coreWData),
        .coreAck    (coreAck),
        .coreRData  (coreRData),
        .memWriteEn (memWriteEn),
        .memAddress (memAddress),
        .memDataIn  (memDataIn),
        .memDataOut (memDataOut),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Single-port data memory: registered address, write on the edge.
    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] mem_aq = '0;
    always @(posedge clock) begin
        if (memWriteEn) mem[memAddress] <= memDataIn;
        mem_aq <= memAddress;
    end
    assign memDataOut = mem[mem_aq];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int core;
        bit we;
        int data;
        int cyc;
    } exp_t;
    exp_t expq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int ref_mem [0:(1<<AW)-1];
    int m_last;
    int next_free;
    bit m_en = 1'b0;
    int last_grant_cyc = -1;

    // Core-side state
    bit pend [N];
    bit pwe [N];
    int paddr [N];
    int pdata [N];
    bit persist [N];
    int rnd_pct = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int c, input bit we, input int addr, input int data);
        pend[c]  = 1'b1;
        pwe[c]   = we;
        paddr[c] = addr;
        pdata[c] = data;
    endtask

    task automatic new_op(input int c);
        int a;
        a = ($urandom_range(0, 9) == 0) ? 'h3FF : int'($urandom_range(0, 7));
        issue(c, bit'($urandom_range(0, 1)), a, int'($urandom_range(0, 4095)));
    endtask

    // One cycle of core behaviour plus the transaction-level model, run at
    // the falling edge.
    task automatic step();
        int c;
        for (int i = 0; i < N; i++) begin
            if (coreAck[i] && pend[i]) pend[i] = persist[i];
            if (!pend[i] && rnd_pct > 0 && $urandom_range(0, 99) < rnd_pct) new_op(i);
        end
        for (int i = 0; i < N; i++) begin
            coreReq[i]             = pend[i];
            coreWe[i]              = pwe[i];
            coreAddr[i*AW +: AW]   = AW'(paddr[i]);
            coreWData[i*W +: W]    = W'(pdata[i]);
        end
        if (m_en && cyc >= next_free) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (pend[c]) begin
                    if (pwe[c]) begin
                        expq.push_back('{c, 1'b1, 0, cyc + 2});
                        ref_mem[paddr[c]] = pdata[c];
                        next_free = cyc + 3;
                    end else begin
                        expq.push_back('{c, 1'b0, ref_mem[paddr[c]], cyc + 3});
                        next_free = cyc + 4;
                    end
                    m_last = c;
                    last_grant_cyc = cyc;
                    break;
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clock);
            step();
        end
    endtask

    task automatic clear_cores();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            persist[i] = 1'b0;
        end
        coreReq = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        m_en = 1'b0;
        clear_cores();
        expq.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_last = N - 1;
        next_free = cyc;
        m_en = 1'b1;
    endtask

    task automatic drain();
        int t;
        bit any;
        t = 0;
        any = 1'b1;
        while (any && t < 80) begin
            any = (expq.size() > 0);
            for (int i = 0; i < N; i++) if (pend[i]) any = 1'b1;
            if (any) begin
                run(1);
                t++;
            end
        end
        if (any) chk("drain_timeout", 1, 0);
    endtask

    // Monitor: compares every presented ack against the scoreboard.
    exp_t mon_e;
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                mon_e = expq.pop_front();
                chk("ack_missing_core", -1, mon_e.core);
            end
            if (coreAck != '0) begin
                if (expq.size() == 0) begin
                    chk("ack_unexpected", int'(coreAck), 0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("ack_onehot", int'(coreAck), 1 << mon_e.core);
                    chk("ack_cycle", cyc, mon_e.cyc);
                    if (!mon_e.we) chk("read_data", int'(coreRData), mon_e.data);
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a] = '0;
            ref_mem[a] = 0;
        end
        clear_cores();

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(coreAck), 0);
        chk("rst_we", int'(memWriteEn), 0);
        chk("rst_addr", int'(memAddress), 0);
        chk("rst_din", int'(memDataIn), 0);
        chk("rst_rdata", int'(coreRData), 0);
        reset = 1'b0;
        m_last = N - 1;
        next_free = cyc;
        m_en = 1'b1;

        // Core 1 writes 0xABC at 5, then reads it back
        issue(1, 1'b1, 5, 'hABC);
        drain();
        issue(1, 1'b0, 5, 0);
        drain();

        // All four cores read continuously: grants rotate 0,1,2,3,0...
        do_reset();
        issue(0, 1'b0, 5, 0);
        issue(1, 1'b0, 6, 0);
        issue(2, 1'b0, 7, 0);
        issue(3, 1'b0, 'h3FF, 0);
        for (int i = 0; i < N; i++) persist[i] = 1'b1;
        run(22);
        for (int i = 0; i < N; i++) persist[i] = 1'b0;
        drain();

        // Contention wrap: last grant 2, then cores 0 and 3 -> 3 first
        do_reset();
        issue(2, 1'b0, 7, 0);
        drain();
        issue(0, 1'b0, 5, 0);
        issue(3, 1'b0, 'h3FF, 0);
        drain();

        // Read-after-write at the top address across consecutive grants
        do_reset();
        issue(0, 1'b1, 'h3FF, 'h123);
        issue(2, 1'b0, 'h3FF, 0);
        drain();

        // Reset during RDWAIT
        do_reset();
        issue(1, 1'b0, 5, 0);
        last_grant_cyc = -1;
        begin
            int t;
            t = 0;
            while (last_grant_cyc < 0 && t < 10) begin
                run(1);
                t++;
            end
            if (last_grant_cyc < 0) chk("grant_timeout", 1, 0);
            t = 0;
            while (cyc < last_grant_cyc + 2 && t < 10) begin
                run(1);
                t++;
            end
        end
        reset = 1'b1;
        m_en = 1'b0;
        clear_cores();
        expq.delete();
        #1;
        chk("midrst_ack", int'(coreAck), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_we", int'(memWriteEn), 0);
        @(negedge clock);
        chk("midrst_ack_hold", int'(coreAck), 0);
        reset = 1'b0;
        m_last = N - 1;
        next_free = cyc;
        m_en = 1'b1;
        issue(0, 1'b0, 5, 0);
        drain();

        // Idle: nothing moves for 20 cycles
        repeat (20) begin
            @(negedge clock);
            step();
            chk("idle_we", int'(memWriteEn), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_ack", int'(coreAck), 0);
        end

        // Randomized traffic
        rnd_pct = 30;
        run(400);
        rnd_pct = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
